// File: rtl/ddr_app_arbiter.sv
// Round-robin N-channel burst front-end for the MIG app interface.
// Splits each granted burst into per-beat commands; write data always leads its command.
module ddr_app_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 30,
  parameter int APP_DATA_WIDTH = 512,
  parameter int LEN_WIDTH      = 8,
  parameter int ADDR_STEP      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_calib_complete,
  input  logic [NUM_CH-1:0]                ch_req,
  input  logic [NUM_CH-1:0]                ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]      ch_len,
  input  logic [NUM_CH*APP_DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]                ch_wpop,
  output logic [NUM_CH-1:0]                ch_gnt,
  output logic [NUM_CH-1:0]                ch_done,
  output logic [APP_DATA_WIDTH-1:0]        rd_data,
  output logic [NUM_CH-1:0]                rd_valid,
  output logic [ADDR_WIDTH-1:0]            app_addr,
  output logic [2:0]                       app_cmd,
  output logic                             app_en,
  output logic [APP_DATA_WIDTH-1:0]        app_wdf_data,
  output logic                             app_wdf_end,
  output logic [APP_DATA_WIDTH/8-1:0]      app_wdf_mask,
  output logic                             app_wdf_wren,
  input  logic                             app_rdy,
  input  logic                             app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]        app_rd_data,
  input  logic                             app_rd_data_valid
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         gsel, rr_ptr, pick, cand;
  logic                  found;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [CW-1:0]         cmd_cnt, dat_cnt, ret_cnt, last;
  logic [NUM_CH-1:0]     g_oh;
  logic                  wr_acc, cmd_acc, grant;

  assign last = CW'(len) + CW'(1);
  assign g_oh = NUM_CH'(1) << gsel;

  // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_CH);
      if (ch_req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_cmd      = 3'b000;
    ch_gnt       = '0;
    ch_done      = '0;
    case (state)
      IDLE: if (init_calib_complete && found) state_nxt = ch_we[pick] ? WR : RD;
      WR: begin
        ch_gnt       = g_oh;
        app_wdf_wren = (dat_cnt < last);
        app_en       = (cmd_cnt < dat_cnt);
        if (cmd_cnt == last) state_nxt = DONE;
      end
      RD: begin
        ch_gnt  = g_oh;
        app_cmd = 3'b001;
        app_en  = (cmd_cnt < last);
        if (ret_cnt == last) state_nxt = DONE;
      end
      DONE: begin
        ch_done   = g_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant        = (state == IDLE) && (state_nxt != IDLE);
  assign wr_acc       = app_wdf_wren & app_wdf_rdy;
  assign cmd_acc      = app_en & app_rdy;
  assign ch_wpop      = wr_acc ? g_oh : '0;
  assign app_addr     = cmd_addr;
  assign app_wdf_data = app_wdf_wren ? ch_wdata[int'(gsel)*APP_DATA_WIDTH +: APP_DATA_WIDTH] : '0;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gsel     <= '0;
      rr_ptr   <= '0;
      cmd_addr <= '0;
      len      <= '0;
      cmd_cnt  <= '0;
      dat_cnt  <= '0;
      ret_cnt  <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      if (grant) begin
        gsel     <= pick;
        cmd_addr <= ch_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        len      <= ch_len[int'(pick)*LEN_WIDTH +: LEN_WIDTH];
        cmd_cnt  <= '0;
        dat_cnt  <= '0;
        ret_cnt  <= '0;
      end else begin
        // Address wraps naturally at 2^ADDR_WIDTH.
        if (cmd_acc) begin
          cmd_cnt  <= cmd_cnt + CW'(1);
          cmd_addr <= cmd_addr + ADDR_WIDTH'(ADDR_STEP);
        end
        if (wr_acc) dat_cnt <= dat_cnt + CW'(1);
        if (state == RD && app_rd_data_valid) ret_cnt <= ret_cnt + CW'(1);
      end
      rd_valid <= (state == RD && app_rd_data_valid) ? g_oh : '0;
      if (state == RD && app_rd_data_valid) rd_data <= app_rd_data;
      if (state == DONE) rr_ptr <= (gsel == IW'(NUM_CH - 1)) ? '0 : gsel + IW'(1);
    end
  end

endmodule

// File: doc/ddr_app_arbiter.md
# ddr_app_arbiter

Parametrised N-channel burst front-end for the DDR3 MIG user (app) interface, sitting between the accelerator's load/store engines and the memory controller in the `clk`/`rst` (ui_clk / ui_clk_sync_rst) domain. Each channel requests a read or write burst of up to 2^LEN_WIDTH beats. The block grants channels round-robin once calibration completes and splits each burst into per-beat app commands with an incrementing address. It keeps write data strictly ahead of write commands and routes read data back to the owning channel.

## Interface
- NUM_CH, 4: number of requesting channels (≥2).
- ADDR_WIDTH, 30: app_addr width.
- APP_DATA_WIDTH, 512: app data width (one beat = one BL8 command).
- LEN_WIDTH, 8: burst length field; burst = len+1 beats.
- ADDR_STEP, 8: app_addr increment per beat.

Ports:
- clk  in  1  ui clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- init_calib_complete  in  1  MIG calibration done; no grant while low.
- ch_req  in  NUM_CH  burst request, level, held until ch_done.
- ch_we  in  NUM_CH  1 = write burst, 0 = read.
- ch_addr  in  NUM_CH*ADDR_WIDTH  burst base address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_len  in  NUM_CH*LEN_WIDTH  beats-1.
- ch_wdata  in  NUM_CH*APP_DATA_WIDTH  first-word-fall-through write data per channel.
- ch_wpop  out  NUM_CH  one-hot pulse; write beat consumed, channel presents next word next cycle.
- ch_gnt  out  NUM_CH  one-hot; channel owns the controller.
- ch_done  out  NUM_CH  one-cycle pulse at burst completion.
- rd_data  out  APP_DATA_WIDTH  read beat (shared).
- rd_valid  out  NUM_CH  one-hot; rd_data valid for that channel.
- app_addr, app_cmd[2:0], app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren  out  to MIG.
- app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid  in  from MIG.

## Operation
- States: IDLE, WR, RD, DONE.
- IDLE: if init_calib_complete and any ch_req, pick the first requester at or after rr_ptr (wrapping). Latch its index, ch_addr, ch_len, and ch_we, then go to WR or RD. ch_gnt is asserted from the next cycle.
- Counters: cmd_cnt, dat_cnt, ret_cnt, each LEN_WIDTH+1 bits wide and cleared on grant.
- WR, data path:
  - app_wdf_wren is high while dat_cnt ≤ len.
  - app_wdf_data = granted ch_wdata slice; app_wdf_end = app_wdf_wren; app_wdf_mask = 0.
  - A beat is accepted when app_wdf_wren & app_wdf_rdy: ch_wpop[g] pulses the same cycle and dat_cnt increments.
- WR, command path:
  - app_en is high while cmd_cnt < dat_cnt (data-first ordering; a command never precedes its data).
  - app_cmd = 3'b000; app_addr = base + cmd_cnt*ADDR_STEP, modulo 2^ADDR_WIDTH.
  - A command is accepted when app_en & app_rdy; cmd_cnt then increments.
- WR exits to DONE when cmd_cnt == len+1.
- RD:
  - app_en is high while cmd_cnt ≤ len; app_cmd = 3'b001; address as in WR.
  - Each app_rd_data_valid drives rd_data = app_rd_data and rd_valid[g], registered with one cycle latency, and increments ret_cnt.
  - RD exits to DONE when ret_cnt == len+1 and the last beat has been forwarded.
- DONE (one cycle): ch_done[g]=1, ch_gnt drops, rr_ptr = g+1 mod NUM_CH, then IDLE.
- app_rd_data_valid while not in RD is ignored (no rd_valid).
- init_calib_complete falling during a burst does not abort the burst; it only blocks new grants.
- ch_req deasserting mid-burst is ignored; the burst runs to completion.
- Reset values: all outputs 0 (app_en, app_wdf_wren, ch_gnt, ch_done, ch_wpop, rd_valid, app_cmd=000, app_addr=0). State=IDLE, rr_ptr=0, counters 0.
- Reset mid-burst aborts immediately. Any in-flight MIG reads are the integrator's responsibility, since the MIG is reset from the same source.

## Timing
- Request to ch_gnt: 1 cycle (IDLE registers the grant).
- Grant to first app_wdf_wren / app_en(read): next cycle.
- Write command app_en: earliest one cycle after its data beat is accepted.
- Peak throughput: one beat per cycle with app_rdy and app_wdf_rdy held high. A write of L beats takes L+1 cycles from first wren to last command.
- Read return: rd_valid exactly one cycle after app_rd_data_valid.
- app_en / app_wdf_wren stay asserted with stable address/data until accepted; no de-assertion without a handshake.
- DONE to next grant: IDLE takes one cycle, so at least 2 cycles between bursts.

## Test plan
- Single write, ch1, addr=0x100, len=3, MIG always ready:
  - four ch_wpop[1] pulses;
  - app_addr 0x100, 0x108, 0x110, 0x118 each with cmd 000;
  - ch_done[1] once; no command before its data beat.
- Single read, ch0, addr=0x3FFFFFF8 (ADDR_WIDTH=30), len=1:
  - addresses 0x3FFFFFF8 then 0x00000000 (wrap);
  - two rd_valid[0] pulses, each 1 cycle after app_rd_data_valid.
- All four channels requesting from reset with calib high: grants in order 0,1,2,3,0. Each subsequent grant is ≥2 cycles after the previous ch_done.
- Back-pressure: toggle app_rdy/app_wdf_rdy pseudo-randomly on a len=15 write. Required:
  - app_addr and app_wdf_data stable while unaccepted;
  - exactly 16 commands, 16 data beats;
  - cmd_cnt never exceeds dat_cnt.
- ch_req held with init_calib_complete=0 for 50 cycles: no ch_gnt. Raise calib: ch_gnt next cycle.
- Assert rst during RD after 2 of 8 commands: all outputs 0 asynchronously, state IDLE. After release, a new request is granted normally.
